// File: rtl/amm_arb_pkg.sv
// Shared types for the two-master Avalon-MM burst arbiter and its read-return tracker.
package amm_arb_pkg;

   localparam int RD_LEN_W = 11;

   typedef enum logic {IDLE, WR_LOCK} arb_state_t;

   typedef logic master_id_t;

   typedef struct packed {
      master_id_t            id;
      logic [RD_LEN_W-1:0]   len;
   } rd_entry_t;

   // A burstcount of zero is carried as a single beat everywhere.
   function automatic logic [RD_LEN_W-1:0] eff_len(input logic [RD_LEN_W-1:0] bc);
      return (bc == '0) ? RD_LEN_W'(1) : bc;
   endfunction

endpackage

// File: rtl/amm_arb_rd_tracker.sv
// Outstanding-read FIFO: remembers which master issued each read burst and
// counts returning beats so the head entry retires on its final beat.
module amm_arb_rd_tracker
   import amm_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  rd_entry_t  push_entry,
   input  logic       beat,
   output logic       full,
   output logic       empty,
   output master_id_t head_id
);

   localparam int PTR_W = $clog2(DEPTH);

   rd_entry_t             mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W:0]        count;
   logic [RD_LEN_W-1:0]   head_beats;
   logic                  push_ok;
   logic                  pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head_id = mem[rd_ptr].id;
   assign push_ok = push & ~full;
   assign pop     = beat & ~empty & (head_beats == mem[rd_ptr].len - RD_LEN_W'(1));

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_beats <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (pop)                head_beats <= '0;
         else if (beat && !empty) head_beats <= head_beats + RD_LEN_W'(1);
      end
   end

endmodule

// File: rtl/amm_burst_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst slave between m0 and m1;
// write bursts lock the grant, read bursts are tracked for return routing.
//
// state   | meaning
// IDLE    | combinational round-robin grant among eligible requesters
// WR_LOCK | grant held by owner until the last beat of its write burst
module amm_burst_arbiter
   import amm_arb_pkg::*;
#(
   parameter int ADDR_W       = 31,
   parameter int DATA_W       = 64,
   parameter int BURST_W      = RD_LEN_W,
   parameter int MAX_RD_OUTST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [BURST_W-1:0]  m0_burstcount,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [BURST_W-1:0]  m1_burstcount,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic [BURST_W-1:0]  s_burstcount,
   output logic [DATA_W-1:0]   s_writedata,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   input  logic                s_waitrequest,
   output logic                err_unexp_rdv
);

   arb_state_t          state, next_state;
   master_id_t          grant, owner, last_grant, head_id;
   logic                grant_valid, req0, req1, accept;
   logic                sel_read, sel_write;
   logic [BURST_W-1:0]  beat_cnt, first_cnt;
   logic                rd_full, rd_empty;
   rd_entry_t           push_entry;

   always_comb begin
      grant          = 1'b0;
      grant_valid    = 1'b0;
      next_state     = state;
      // A read cannot be taken while the tracker is full, so it is not eligible.
      req0 = m0_write | (m0_read & ~rd_full);
      req1 = m1_write | (m1_read & ~rd_full);
      case (state)
         IDLE: begin
            grant_valid = req0 | req1;
            grant       = (req0 && req1) ? ~last_grant : req1;
         end
         WR_LOCK: begin
            grant       = owner;
            grant_valid = 1'b1;
         end
         default: ;
      endcase

      sel_read     = grant ? m1_read       : m0_read;
      sel_write    = grant ? m1_write      : m0_write;
      s_address    = grant ? m1_address    : m0_address;
      s_byteenable = grant ? m1_byteenable : m0_byteenable;
      s_burstcount = grant ? m1_burstcount : m0_burstcount;
      s_writedata  = grant ? m1_writedata  : m0_writedata;

      s_read  = grant_valid & sel_read & ~rd_full & (state == IDLE);
      s_write = grant_valid & sel_write;
      accept  = (s_read | s_write) & ~s_waitrequest;

      m0_waitrequest = ~(grant_valid & (grant == 1'b0)) | s_waitrequest;
      m1_waitrequest = ~(grant_valid & (grant == 1'b1)) | s_waitrequest;

      case (state)
         IDLE:    if (s_write && accept && first_cnt != '0) next_state = WR_LOCK;
         WR_LOCK: if (s_write && accept && beat_cnt == BURST_W'(1)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign first_cnt = BURST_W'(eff_len(RD_LEN_W'(s_burstcount))) - BURST_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
      end else begin
         state <= next_state;
         if (accept) last_grant <= grant;
         if (state == IDLE && s_write && accept) begin
            owner    <= grant;
            beat_cnt <= first_cnt;
         end else if (state == WR_LOCK && s_write && accept) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
         end
      end
   end

   assign push_entry = '{id: grant, len: eff_len(RD_LEN_W'(s_burstcount))};

   amm_arb_rd_tracker #(.DEPTH(MAX_RD_OUTST)) u_rd_tracker (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (s_read & ~s_waitrequest),
      .push_entry (push_entry),
      .beat       (s_readdatavalid),
      .full       (rd_full),
      .empty      (rd_empty),
      .head_id    (head_id)
   );

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = s_readdatavalid & ~rd_empty & (head_id == 1'b0);
   assign m1_readdatavalid = s_readdatavalid & ~rd_empty & (head_id == 1'b1);
   assign err_unexp_rdv    = s_readdatavalid & rd_empty;

endmodule

// File: tb/tb_amm_burst_arbiter.sv
// Scoreboard bench for amm_burst_arbiter: read beats are expected in issue order
// per master, with a simple slave model that can withhold returned data.
module tb_amm_burst_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [30:0] m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [7:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic [10:0] m0_burstcount, m1_burstcount, s_burstcount;
   logic [63:0] m0_writedata, m1_writedata, s_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [63:0] m0_readdata, m1_readdata, s_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        s_read, s_write, s_readdatavalid, s_waitrequest, err_unexp_rdv;

   int   n_chk = 0, n_fail = 0;
   bit   exp_q[$];
   bit   rdv_log[$];
   int   pending_beats = 0;
   int   rdv_cnt = 0, err_cnt = 0;
   bit   rd_hold = 1'b0;
   logic [63:0] data_seq = 64'h1000;

   always #5 clk = ~clk;

   amm_burst_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
      .s_writedata(s_writedata), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
      .err_unexp_rdv(err_unexp_rdv)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int beats_of(input logic [10:0] bc);
      return (bc == 0) ? 1 : int'(bc);
   endfunction

   // Slave model: returns one beat per cycle for every accepted read beat unless held.
   always @(posedge clk) begin
      #1;
      if (!rd_hold && pending_beats > 0) begin
         s_readdatavalid = 1'b1;
         s_readdata      = data_seq;
         data_seq        = data_seq + 1;
         pending_beats   = pending_beats - 1;
      end else begin
         s_readdatavalid = 1'b0;
      end
   end

   // Monitor: check returned beats against the scoreboard, then record new reads.
   always @(negedge clk) begin
      if (s_readdatavalid) begin
         rdv_cnt++;
         if (exp_q.size() == 0) begin
            err_cnt++;
            chk("unexp_err", err_unexp_rdv, 1'b1);
            chk("unexp_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
         end else begin
            bit id;
            id = exp_q.pop_front();
            rdv_log.push_back(m1_readdatavalid);
            chk("rdv_m0", m0_readdatavalid, id == 1'b0);
            chk("rdv_m1", m1_readdatavalid, id == 1'b1);
            chk("rd_err", err_unexp_rdv, 1'b0);
            chk("rd_data", id ? m1_readdata : m0_readdata, s_readdata);
         end
      end
      if (m0_read && !m0_waitrequest) begin
         chk("rd_addr_m0", s_address, m0_address);
         for (int i = 0; i < beats_of(m0_burstcount); i++) exp_q.push_back(1'b0);
         pending_beats += beats_of(m0_burstcount);
      end
      if (m1_read && !m1_waitrequest) begin
         chk("rd_addr_m1", s_address, m1_address);
         for (int i = 0; i < beats_of(m1_burstcount); i++) exp_q.push_back(1'b1);
         pending_beats += beats_of(m1_burstcount);
      end
      if (m0_write && !m0_waitrequest) chk("wr_data_m0", s_writedata, m0_writedata);
      if (m1_write && !m1_waitrequest) chk("wr_data_m1", s_writedata, m1_writedata);
   end

   task automatic set_cmd(input bit id, input bit rd, input bit wr, input logic [30:0] addr,
                          input logic [10:0] bc, input logic [63:0] wdata);
      if (id) begin
         m1_read = rd; m1_write = wr; m1_address = addr; m1_burstcount = bc; m1_writedata = wdata;
      end else begin
         m0_read = rd; m0_write = wr; m0_address = addr; m0_burstcount = bc; m0_writedata = wdata;
      end
   endtask

   // Drive one command (all beats for a write) and wait for acceptance, bounded.
   task automatic issue(input bit id, input bit wr, input logic [30:0] addr,
                        input logic [10:0] bc, input logic [63:0] wdata);
      int need, done, cyc;
      need = wr ? beats_of(bc) : 1;
      done = 0;
      cyc  = 0;
      set_cmd(id, !wr, wr, addr, bc, wdata);
      while (done < need && cyc < 200) begin
         @(negedge clk);
         if (!(id ? m1_waitrequest : m0_waitrequest)) done++;
         @(posedge clk); #1;
         cyc++;
         if (wr) set_cmd(id, 1'b0, 1'b1, addr, bc, wdata + 64'(done));
      end
      set_cmd(id, 1'b0, 1'b0, addr, bc, wdata);
      chk("issue_done", done, need);
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((exp_q.size() != 0 || pending_beats != 0) && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_in_time", c < 300, 1'b1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_wait"}, {m0_waitrequest, m1_waitrequest}, 2'b11);
      chk({tag, "_cmd"}, {s_read, s_write}, 2'b00);
      chk({tag, "_rdv"}, {m0_readdatavalid, m1_readdatavalid, err_unexp_rdv}, 3'b000);
   endtask

   initial begin
      bit [5:0] pat;
      int mark, c;
      rst_n = 1'b0;
      s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
      m0_byteenable = '1; m1_byteenable = '1;
      set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0);
      set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // Simultaneous single-beat reads: m0 first, then m1.
      @(posedge clk); #1;
      rdv_log.delete();
      set_cmd(1'b0, 1'b1, 1'b0, 31'h100, 11'd1, '0);
      set_cmd(1'b1, 1'b1, 1'b0, 31'h200, 11'd1, '0);
      @(negedge clk);
      chk("tie_m0_wait", m0_waitrequest, 1'b0);
      chk("tie_m1_wait", m1_waitrequest, 1'b1);
      @(posedge clk); #1;
      m0_read = 1'b0;
      @(negedge clk);
      chk("tie_m1_next", m1_waitrequest, 1'b0);
      @(posedge clk); #1;
      m1_read = 1'b0;
      wait_drain();
      chk("tie_order_len", rdv_log.size(), 2);
      if (rdv_log.size() == 2) chk("tie_order", {rdv_log[0], rdv_log[1]}, 2'b01);

      // m1 write burst of 4 with slave stall; m0 read must wait until after beat 4.
      set_cmd(1'b1, 1'b0, 1'b1, 31'h300, 11'd4, 64'hA0);
      @(negedge clk);
      chk("lk_b1_m1", m1_waitrequest, 1'b0);
      @(posedge clk); #1;
      set_cmd(1'b0, 1'b1, 1'b0, 31'h140, 11'd1, '0);
      m1_writedata = 64'hA1;
      @(negedge clk);
      chk("lk_b2_m1", m1_waitrequest, 1'b0);
      chk("lk_b2_m0", m0_waitrequest, 1'b1);
      @(posedge clk); #1;
      m1_writedata = 64'hA2;
      s_waitrequest = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("lk_stall_m1", m1_waitrequest, 1'b1);
         chk("lk_stall_m0", m0_waitrequest, 1'b1);
         chk("lk_stall_read", s_read, 1'b0);
         @(posedge clk); #1;
      end
      s_waitrequest = 1'b0;
      @(negedge clk);
      chk("lk_b3_m1", m1_waitrequest, 1'b0);
      chk("lk_b3_m0", m0_waitrequest, 1'b1);
      @(posedge clk); #1;
      m1_writedata = 64'hA3;
      @(negedge clk);
      chk("lk_b4_m1", m1_waitrequest, 1'b0);
      chk("lk_b4_m0", m0_waitrequest, 1'b1);
      chk("lk_b4_data", s_writedata, 64'hA3);
      @(posedge clk); #1;
      m1_write = 1'b0;
      @(negedge clk);
      chk("lk_release_m0", m0_waitrequest, 1'b0);
      @(posedge clk); #1;
      m0_read = 1'b0;
      wait_drain();

      // Tracker full: fifth read stalls, a write still passes.
      rd_hold = 1'b1;
      for (int i = 0; i < 4; i++) issue(1'b0, 1'b0, 31'h400 + 31'(i * 8), 11'd8, '0);
      set_cmd(1'b0, 1'b1, 1'b0, 31'h480, 11'd1, '0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("full_m0_wait", m0_waitrequest, 1'b1);
         chk("full_no_read", s_read, 1'b0);
         @(posedge clk); #1;
      end
      set_cmd(1'b1, 1'b0, 1'b1, 31'h500, 11'd1, 64'hB0);
      @(negedge clk);
      chk("full_wr_pass", {m1_waitrequest, s_write}, 2'b01);
      chk("full_wr_m0", m0_waitrequest, 1'b1);
      @(posedge clk); #1;
      m1_write = 1'b0;
      mark = rdv_cnt;
      rd_hold = 1'b0;
      c = 0;
      @(negedge clk);
      while (m0_waitrequest && c < 40) begin
         @(negedge clk);
         c++;
      end
      chk("full_release_seen", c < 40, 1'b1);
      chk("full_after_8", (rdv_cnt - mark) >= 8, 1'b1);
      @(posedge clk); #1;
      m0_read = 1'b0;
      wait_drain();

      // Interleaved reads: return pattern 0,0,0,1,1,0.
      rd_hold = 1'b1;
      rdv_log.delete();
      issue(1'b0, 1'b0, 31'h600, 11'd3, '0);
      issue(1'b1, 1'b0, 31'h700, 11'd2, '0);
      issue(1'b0, 1'b0, 31'h680, 11'd1, '0);
      rd_hold = 1'b0;
      wait_drain();
      pat = '0;
      foreach (rdv_log[i]) pat = {pat[4:0], rdv_log[i]};
      chk("ilv_len", rdv_log.size(), 6);
      chk("ilv_pattern", pat, 6'b000110);

      // burstcount 0 write is one beat; m1 is served next cycle.
      issue(1'b0, 1'b1, 31'h800, 11'd0, 64'hC0);
      set_cmd(1'b1, 1'b1, 1'b0, 31'h880, 11'd1, '0);
      @(negedge clk);
      chk("bc0_idle_m1", m1_waitrequest, 1'b0);
      @(posedge clk); #1;
      m1_read = 1'b0;
      wait_drain();

      // Reset inside a write lock with two reads outstanding.
      rd_hold = 1'b1;
      issue(1'b1, 1'b0, 31'h900, 11'd2, '0);
      issue(1'b1, 1'b0, 31'h910, 11'd2, '0);
      set_cmd(1'b1, 1'b0, 1'b1, 31'h920, 11'd4, 64'hD0);
      @(negedge clk);
      chk("rst_wr_b1", m1_waitrequest, 1'b0);
      @(posedge clk); #1;
      set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_idle_outputs("postrst");
      mark = err_cnt;
      rd_hold = 1'b0;
      wait_drain();
      chk("late_err_cnt", err_cnt - mark, 4);
      set_cmd(1'b0, 1'b1, 1'b0, 31'hA00, 11'd1, '0);
      set_cmd(1'b1, 1'b1, 1'b0, 31'hA80, 11'd1, '0);
      @(negedge clk);
      chk("rst_tie_m0", m0_waitrequest, 1'b0);
      chk("rst_tie_m1", m1_waitrequest, 1'b1);
      @(posedge clk); #1;
      m0_read = 1'b0;
      @(negedge clk);
      chk("rst_tie_m1_next", m1_waitrequest, 1'b0);
      @(posedge clk); #1;
      m1_read = 1'b0;
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
